// File: rtl/mux_gate_pkg.sv
// Shared definitions for the mux-as-universal-gate scan controller.
// Holds gate codes, their 8-bit truth-table patterns, and the scan FSM states.
package mux_gate_pkg;

    // Gate codes as presented on gate_sel
    localparam logic [2:0] GATE_AND  = 3'd0;
    localparam logic [2:0] GATE_OR   = 3'd1;
    localparam logic [2:0] GATE_NAND = 3'd2;
    localparam logic [2:0] GATE_NOR  = 3'd3;
    localparam logic [2:0] GATE_XOR  = 3'd4;
    localparam logic [2:0] GATE_XNOR = 3'd5;
    localparam logic [2:0] GATE_NOT  = 3'd6;
    localparam logic [2:0] GATE_BUF  = 3'd7;

    // Truth tables: bit k is the gate output for select value k.
    // NOT and BUF only look at s[0].
    localparam logic [7:0] TT_AND  = 8'h80;
    localparam logic [7:0] TT_OR   = 8'hFE;
    localparam logic [7:0] TT_NAND = 8'h7F;
    localparam logic [7:0] TT_NOR  = 8'h01;
    localparam logic [7:0] TT_XOR  = 8'h96;
    localparam logic [7:0] TT_XNOR = 8'h69;
    localparam logic [7:0] TT_NOT  = 8'h55;
    localparam logic [7:0] TT_BUF  = 8'hAA;

    // Scan FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_DRIVE  = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_t;

endpackage

// File: rtl/gate_tt_rom.sv
// Combinational gate-code to truth-table lookup. The same pattern is driven
// onto the mux data inputs and used as the expected scan response.
module gate_tt_rom
    import mux_gate_pkg::*;
(
    input  logic [2:0] gate_sel,
    output logic [7:0] pattern
);

    // Map each gate code onto its 8-entry truth table
    always_comb begin
        pattern = TT_AND;
        case (gate_sel)
            GATE_AND:  pattern = TT_AND;
            GATE_OR:   pattern = TT_OR;
            GATE_NAND: pattern = TT_NAND;
            GATE_NOR:  pattern = TT_NOR;
            GATE_XOR:  pattern = TT_XOR;
            GATE_XNOR: pattern = TT_XNOR;
            GATE_NOT:  pattern = TT_NOT;
            GATE_BUF:  pattern = TT_BUF;
            default:   pattern = TT_AND;
        endcase
    end

endmodule

// File: rtl/mux_gate_scan_ctrl.sv
// Scan controller for an 8:1 mux used as a universal gate: loads the selected
// gate's truth table onto mux_i, walks mux_s through 0..7 sampling mux_y, and
// reports the assembled response with a one-cycle done pulse and pass flag.
// Optional build macro MUX_SCAN_ERRCNT_EN adds a saturating failed-scan
// counter on output err_cnt.
//
// Request handshake: start is a level request accepted on any clock edge where
// busy is low (state IDLE); gate_sel is captured on that same edge. While busy
// is high, start and gate_sel are ignored and nothing is queued. done pulses
// for exactly one cycle per completed scan, and result/pass are valid from
// that cycle until the next accepted start.
module mux_gate_scan_ctrl
    import mux_gate_pkg::*;
#(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] gate_sel,
    output logic [7:0] mux_i,
    output logic [2:0] mux_s,
    input  logic       mux_y,
    output logic       busy,
    output logic       done,
    output logic [7:0] result,
    output logic       pass
`ifdef MUX_SCAN_ERRCNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);

    // Last settle count value before moving on to SAMPLE
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    scan_state_t      state_q, state_d;
    logic [2:0]       gate_q;
    logic [CNT_W-1:0] cnt_q;
    logic [7:0]       pattern;
    logic [7:0]       result_smp;

    gate_tt_rom u_rom (
        .gate_sel (gate_q),
        .pattern  (pattern)
    );

    assign busy = (state_q != ST_IDLE);
    assign done = (state_q == ST_DONE);

    // Response with the current mux_y merged in at the current select position
    always_comb begin
        result_smp        = result;
        result_smp[mux_s] = mux_y;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start) state_d = ST_LOAD;
            ST_LOAD:   state_d = ST_DRIVE;
            ST_DRIVE:  if (cnt_q == SETTLE_LAST) state_d = ST_SAMPLE;
            ST_SAMPLE: state_d = (mux_s == 3'd7) ? ST_DONE : ST_DRIVE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Scan datapath: gate capture, mux drive, settle timing and result assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_q <= GATE_AND;
            cnt_q  <= '0;
            mux_i  <= '0;
            mux_s  <= '0;
            result <= '0;
            pass   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) gate_q <= gate_sel;
                end
                ST_LOAD: begin
                    mux_i  <= pattern;
                    mux_s  <= '0;
                    result <= '0;
                    pass   <= 1'b0;
                    cnt_q  <= '0;
                end
                ST_DRIVE: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                ST_SAMPLE: begin
                    result <= result_smp;
                    if (mux_s == 3'd7) begin
                        // Compare here so pass is already valid in the done cycle
                        pass <= (result_smp == pattern);
                    end else begin
                        mux_s <= mux_s + 3'd1;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MUX_SCAN_ERRCNT_EN
    // Count failed scans, saturating; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt <= '0;
        end else if (state_q == ST_DONE && !pass && err_cnt != 8'hFF) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mux_gate_scan_ctrl.sv
// Directed bench for mux_gate_scan_ctrl driving a behavioural 8:1 mux.
module tb_mux_gate_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] gate_sel;
    logic [7:0] mux_i;
    logic [2:0] mux_s;
    logic       mux_y;
    logic       busy;
    logic       done;
    logic [7:0] result;
    logic       pass;
`ifdef MUX_SCAN_ERRCNT_EN
    logic [7:0] err_cnt;
`endif

    logic       force_s7;
    int         n_checks;
    int         n_fail;
    int         done_cnt;
    logic [7:0] exp_q[$];

    mux_gate_scan_ctrl #(.SETTLE_CYCLES(1), .CNT_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .gate_sel (gate_sel),
        .mux_i    (mux_i),
        .mux_s    (mux_s),
        .mux_y    (mux_y),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .pass     (pass)
`ifdef MUX_SCAN_ERRCNT_EN
        ,
        .err_cnt  (err_cnt)
`endif
    );

    // 8:1 mux, with an optional stuck-at-0 output while select is 7
    always_comb begin
        mux_y = mux_i[mux_s];
        if (force_s7 && mux_s == 3'd7) mux_y = 1'b0;
    end

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every done pulse seen at a clock edge
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input logic [2:0] g);
        gate_sel = g;
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    // Wait for done with a cycle budget; returns cycles waited
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
    endtask

    // One full scan: start, latency, result, pass, mux_i, done pulse width
    task automatic run_scan(input logic [2:0] g, input logic [7:0] exp_r,
                            input logic [7:0] exp_i, input logic exp_p,
                            input bit chk_steps);
        int         cyc;
        logic [7:0] e;
        exp_q.push_back(exp_r);
        pulse_start(g);
        check("busy_after_start", 32'(busy), 32'd1);
        cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
            if (chk_steps && cyc == 1) check("busy_e0p1", 32'(busy), 32'd1);
            if (chk_steps && cyc[0] && cyc <= 15) check("mux_s_step", 32'(mux_s), 32'((cyc - 1) / 2));
        end
        check("latency", 32'(cyc), 32'd17);
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e));
        check("pass", 32'(pass), 32'(exp_p));
        check("mux_i", 32'(mux_i), 32'(exp_i));
        tick();
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    logic [7:0] tt_tab [0:7];

    initial begin
        int cyc;
        int d0;
        n_checks = 0;
        n_fail   = 0;
        done_cnt = 0;
        force_s7 = 1'b0;
        start    = 1'b0;
        gate_sel = 3'd0;
        rst_n    = 1'b0;
        tt_tab[0] = 8'h80; tt_tab[1] = 8'hFE; tt_tab[2] = 8'h7F; tt_tab[3] = 8'h01;
        tt_tab[4] = 8'h96; tt_tab[5] = 8'h69; tt_tab[6] = 8'h55; tt_tab[7] = 8'hAA;

        // Reset values
        tick(); tick();
        check("rst_mux_i", 32'(mux_i), 32'd0);
        check("rst_mux_s", 32'(mux_s), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_pass", 32'(pass), 32'd0);
`ifdef MUX_SCAN_ERRCNT_EN
        check("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        rst_n = 1'b1;
        tick();

        // AND scan with per-step select checks
        run_scan(3'd0, 8'h80, 8'h80, 1'b1, 1'b1);

        // Outputs hold after completion
        tick(); tick();
        check("hold_mux_s", 32'(mux_s), 32'd7);
        check("hold_result", 32'(result), 32'h80);
        check("hold_pass", 32'(pass), 32'd1);

        // Remaining gates
        for (int g = 1; g < 8; g++) begin
            run_scan(3'(g), tt_tab[g], tt_tab[g], 1'b1, 1'b0);
        end

        // Forced failure on step 7 with XOR
        force_s7 = 1'b1;
        run_scan(3'd4, 8'h16, 8'h96, 1'b0, 1'b0);
        force_s7 = 1'b0;
`ifdef MUX_SCAN_ERRCNT_EN
        check("err_cnt_one", 32'(err_cnt), 32'd1);
`endif

        // start and gate_sel change mid-scan are ignored
        d0 = done_cnt;
        pulse_start(3'd4);
        cyc = 0;
        while (mux_s !== 3'd3 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("reach_s3", 32'(mux_s), 32'd3);
        pulse_start(3'd1);
        wait_done(cyc);
        check("mid_done_seen", 32'(done), 32'd1);
        check("mid_result", 32'(result), 32'h96);
        check("mid_pass", 32'(pass), 32'd1);
        repeat (25) tick();
        check("mid_one_done", 32'(done_cnt - d0), 32'd1);
        check("mid_idle", 32'(busy), 32'd0);

        // Reset mid-scan at step 5
        d0 = done_cnt;
        pulse_start(3'd0);
        cyc = 0;
        while (mux_s !== 3'd5 && cyc < 40) begin
            tick();
            cyc++;
        end
        check("reach_s5", 32'(mux_s), 32'd5);
        rst_n = 1'b0;
        #1;
        check("abort_mux_i", 32'(mux_i), 32'd0);
        check("abort_mux_s", 32'(mux_s), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_pass", 32'(pass), 32'd0);
`ifdef MUX_SCAN_ERRCNT_EN
        check("abort_err_cnt", 32'(err_cnt), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        check("abort_no_done", 32'(done_cnt - d0), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        run_scan(3'd2, 8'h7F, 8'h7F, 1'b1, 1'b0);

`ifdef MUX_SCAN_ERRCNT_EN
        // Saturation of the failed-scan counter
        force_s7 = 1'b1;
        for (int n = 0; n < 255; n++) begin
            pulse_start(3'd0);
            wait_done(cyc);
            tick();
        end
        check("err_cnt_ff", 32'(err_cnt), 32'hFF);
        run_scan(3'd0, 8'h00, 8'h80, 1'b0, 1'b0);
        tick();
        check("err_cnt_sat", 32'(err_cnt), 32'hFF);
        force_s7 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
